// File: rtl/i2c_txn_queue.sv
// i2c_txn_queue: FIFO of single-byte I2C write requests feeding the byte master.
// Ports: clk, reset (sync, active-high); host side in_valid/in_ready/in_addr/in_data;
//   master side m_start/m_addr/m_data out, m_done/m_nack in; status err, err_count,
//   level, idle. Optional NACK retry is built when I2C_TXN_RETRY_EN is defined.
module i2c_txn_queue #(
  parameter int DEPTH     = 4,
  parameter int GAP_CYC   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_addr,
  input  logic [7:0]               in_data,
  output logic                     m_start,
  output logic [6:0]               m_addr,
  output logic [7:0]               m_data,
  input  logic                     m_done,
  input  logic                     m_nack,
  output logic                     err,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      GAP_CYC < 1 || MAX_RETRY < 0) begin : g_bad_param
    $error("i2c_txn_queue: illegal parameter value");
  end

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t state;
  state_t state_nx;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  logic            done_ev;
  logic            nack_ev;
  logic            drop;
  logic            retry_now;
  logic            retry_pend;

  logic [GW-1:0]   gap_cnt;
  logic            gap_zero;

  logic            start_nx;
  logic [6:0]      addr_nx;
  logic [7:0]      data_nx;
  logic            err_nx;
  logic [7:0]      ecnt_nx;

  // ---------------- queue ----------------
  assign full     = (cnt == LW'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign level    = cnt;
  assign idle     = empty && (state == S_IDLE);
  assign push     = in_valid && !full;
  assign pop      = (state == S_IDLE) && !empty;
  assign head     = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + LW'(push) - LW'(pop);
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{addr: in_addr, data: in_data};
    end
  end

  // ---------------- completion / retry ----------------
  assign done_ev = (state == S_WAIT) && m_done;
  assign nack_ev = done_ev && m_nack;

`ifdef I2C_TXN_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RW-1:0] retry_cnt;
  logic          can_retry;

  assign can_retry = ({1'b0, retry_cnt} < (RW + 1)'(MAX_RETRY));
  assign retry_now = nack_ev && can_retry;
  assign drop      = nack_ev && !can_retry;

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (pop) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (retry_now) begin
      retry_cnt  <= retry_cnt + 1'b1;
      retry_pend <= 1'b1;
    end else if (state == S_GAP && gap_zero) begin
      retry_pend <= 1'b0;
    end
  end
`else
  assign retry_now  = 1'b0;
  assign retry_pend = 1'b0;
  assign drop       = nack_ev;
`endif

  // ---------------- bus-free gap ----------------
  // A retry leaves GAP straight into ISSUE, skipping the IDLE
  // cycle, so it counts one extra cycle to keep the same spacing.
  assign gap_zero = (gap_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (done_ev) begin
      gap_cnt <= retry_now ? GW'(GAP_CYC) : GW'(GAP_CYC - 1);
    end else if (state == S_GAP && !gap_zero) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!empty) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (m_done) state_nx = S_GAP;
      S_GAP: begin
        if (gap_zero) begin
          state_nx = retry_pend ? S_ISSUE : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start_nx = 1'b0;
    addr_nx  = m_addr;
    data_nx  = m_data;
    err_nx   = drop;
    ecnt_nx  = err_count;
    if (pop) begin
      start_nx = 1'b1;
      addr_nx  = head.addr;
      data_nx  = head.data;
    end
    if (state == S_GAP && gap_zero && retry_pend) begin
      start_nx = 1'b1;
    end
    if (drop && err_count != 8'hFF) begin
      ecnt_nx = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      m_start   <= start_nx;
      m_addr    <= addr_nx;
      m_data    <= data_nx;
      err       <= err_nx;
      err_count <= ecnt_nx;
    end
  end

endmodule

// File: tb/tb_i2c_txn_queue.sv
// Directed self-checking bench for i2c_txn_queue.
// One task per scenario; inputs change #1 after the rising edge.
module tb_i2c_txn_queue;

`ifdef I2C_TXN_RETRY_EN
  localparam int EXP_TRIES = 4;
`else
  localparam int EXP_TRIES = 1;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_addr;
  logic [7:0] in_data;
  logic       m_start;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_done;
  logic       m_nack;
  logic       err;
  logic [7:0] err_count;
  logic [2:0] level;
  logic       idle;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  i2c_txn_queue #(
    .DEPTH(4),
    .GAP_CYC(8),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_data(in_data),
    .m_start(m_start),
    .m_addr(m_addr),
    .m_data(m_data),
    .m_done(m_done),
    .m_nack(m_nack),
    .err(err),
    .err_count(err_count),
    .level(level),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic nack);
    m_done = 1'b1;
    m_nack = nack;
    step();
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  task automatic push1(input logic [6:0] a, input logic [7:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_start === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_start_timeout: got no m_start want pulse", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got %b want 1", idle);
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL reset_level: got %0d want 0", level);
    end
    checks++;
    if (m_start !== 1'b0 || m_addr !== 7'h00 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_master: got %b/%h/%h want 0/00/00",
               m_start, m_addr, m_data);
    end
    checks++;
    if (err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_err: got %b/%0d want 0/0", err, err_count);
    end
  endtask

  task automatic test_basic();
    push1(7'h50, 8'hAA);
    checks++;
    if (level !== 3'd1 || m_start !== 1'b0) begin
      errors++;
      $display("FAIL basic_push: got level=%0d start=%b want 1/0",
               level, m_start);
    end
    step();
    checks++;
    if (m_start !== 1'b1 || m_addr !== 7'h50 || m_data !== 8'hAA) begin
      errors++;
      $display("FAIL basic_issue: got %b/%h/%h want 1/50/aa",
               m_start, m_addr, m_data);
    end
    step();
    checks++;
    if (m_start !== 1'b0 || m_addr !== 7'h50 || m_data !== 8'hAA) begin
      errors++;
      $display("FAIL basic_hold: got %b/%h/%h want 0/50/aa",
               m_start, m_addr, m_data);
    end
    step();
    ack(1'b0);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL basic_gap7: got idle=%b want 0", idle);
    end
    step();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL basic_gap8: got idle=%b want 1", idle);
    end
  endtask

  task automatic test_fill();
    push1(7'h7F, 8'h00);
    wait_start("fill_blocker");
    step();
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (in_ready !== (i <= 4)) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b want %b", i, in_ready, i <= 4);
      end
      in_valid = 1'b1;
      in_addr  = 7'(i);
      in_data  = 8'(8'h10 + i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL fill_level: got %0d want 4", level);
    end
    ack(1'b0);
    for (int k = 1; k <= 4; k++) begin
      wait_start("fill_drain");
      checks++;
      if (m_addr !== 7'(k) || m_data !== 8'(8'h10 + k)) begin
        errors++;
        $display("FAIL fill_order%0d: got %h/%h want %h/%h",
                 k, m_addr, m_data, k, 8'h10 + k);
      end
      step();
      ack(1'b0);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (idle !== 1'b1 || level !== 3'd0) begin
      errors++;
      $display("FAIL fill_empty: got idle=%b level=%0d want 1/0", idle, level);
    end
  endtask

  task automatic test_wrap();
    in_valid = 1'b1;
    in_addr  = 7'h2A;
    in_data  = 8'hA0;
    step();
    in_addr  = 7'h2B;
    in_data  = 8'hB0;
    step();
    in_addr  = 7'h2C;
    in_data  = 8'hC0;
    step();
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd2 || m_addr !== 7'h2A) begin
      errors++;
      $display("FAIL wrap_setup: got level=%0d addr=%h want 2/2a",
               level, m_addr);
    end
    ack(1'b0);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL wrap_pre: got level=%0d want 2", level);
    end
    in_valid = 1'b1;
    in_addr  = 7'h2D;
    in_data  = 8'hD0;
    step();
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd2 || m_start !== 1'b1 || m_addr !== 7'h2B ||
        m_data !== 8'hB0) begin
      errors++;
      $display("FAIL wrap_pushpop: got level=%0d start=%b %h/%h want 2/1 2b/b0",
               level, m_start, m_addr, m_data);
    end
    step();
    ack(1'b0);
    wait_start("wrap_c");
    checks++;
    if (m_addr !== 7'h2C || m_data !== 8'hC0) begin
      errors++;
      $display("FAIL wrap_c: got %h/%h want 2c/c0", m_addr, m_data);
    end
    step();
    ack(1'b0);
    wait_start("wrap_d");
    checks++;
    if (m_addr !== 7'h2D || m_data !== 8'hD0) begin
      errors++;
      $display("FAIL wrap_d: got %h/%h want 2d/d0", m_addr, m_data);
    end
    step();
    ack(1'b0);
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_nack();
    int base;
    base = start_cnt;
    push1(7'h3C, 8'h11);
    for (int a = 0; a < EXP_TRIES; a++) begin
      wait_start("nack");
      checks++;
      if (m_addr !== 7'h3C || m_data !== 8'h11) begin
        errors++;
        $display("FAIL nack_data%0d: got %h/%h want 3c/11", a, m_addr, m_data);
      end
      step();
      ack(1'b1);
      checks++;
      if (err !== (a == EXP_TRIES - 1)) begin
        errors++;
        $display("FAIL nack_err%0d: got %b want %b", a, err,
                 a == EXP_TRIES - 1);
      end
    end
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL nack_count: got %0d want 1", err_count);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL nack_err_pulse: got %b want 0", err);
    end
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (start_cnt - base !== EXP_TRIES || idle !== 1'b1) begin
      errors++;
      $display("FAIL nack_starts: got %0d idle=%b want %0d/1",
               start_cnt - base, idle, EXP_TRIES);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    push1(7'h01, 8'h01);
    wait_start("rmid");
    step();
    for (int i = 0; i < 3; i++) push1(7'(7'h02 + i), 8'h55);
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL rmid_level_pre: got %0d want 3", level);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = start_cnt;
    checks++;
    if (level !== 3'd0 || idle !== 1'b1 || in_ready !== 1'b1 ||
        err_count !== 8'd0) begin
      errors++;
      $display("FAIL rmid_state: got level=%0d idle=%b rdy=%b ecnt=%0d want 0/1/1/0",
               level, idle, in_ready, err_count);
    end
    ack(1'b1);
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (start_cnt !== base || err !== 1'b0 || err_count !== 8'd0 ||
        level !== 3'd0) begin
      errors++;
      $display("FAIL rmid_quiet: got starts=%0d ecnt=%0d level=%0d want %0d/0/0",
               start_cnt, err_count, level, base);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) begin
      push1(7'(i), 8'(i));
      for (int a = 0; a < EXP_TRIES; a++) begin
        wait_start("sat");
        step();
        ack(1'b1);
      end
      if (i == 127) begin
        checks++;
        if (err_count !== 8'd128) begin
          errors++;
          $display("FAIL sat_mid: got %0d want 128", err_count);
        end
      end
      if (i == 254) begin
        checks++;
        if (err_count !== 8'd255) begin
          errors++;
          $display("FAIL sat_255: got %0d want 255", err_count);
        end
      end
      if (i == 255) begin
        checks++;
        if (err_count !== 8'd255 || err !== 1'b1) begin
          errors++;
          $display("FAIL sat_hold: got %0d err=%b want 255/1", err_count, err);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    m_done   = 1'b0;
    m_nack   = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_nack();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
